// File: rtl/cac_pkg.sv
// cac_pkg -- shared definitions for the settings hub.
//   cac_state_e   : hub controller state encoding
//   CAC_MAX_CH    : largest supported number of request channels
//   cac_rom_word  : default-settings image, word idx (caller truncates to DATA_WIDTH)
package cac_pkg;

    localparam int CAC_MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } cac_state_e;

    // Default settings image: a simple arithmetic pattern so every word differs.
    function automatic logic [31:0] cac_rom_word(input int unsigned idx);
        return 32'h0000_5A00 + idx * 32'h0000_0111;
    endfunction

endpackage

// File: rtl/cac_rr_arbiter.sv
// cac_rr_arbiter -- round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (one bit per channel)
//   accept     : strobe; moves the priority pointer past the current winner
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted channel
module cac_rr_arbiter
    import cac_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] last_q, last_d;
    logic             found;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && req[IDX_W'((int'(last_q) + i) % NUM_CH)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'((int'(last_q) + i) % NUM_CH);
                grant[IDX_W'((int'(last_q) + i) % NUM_CH)] = 1'b1;
            end
        end
        last_d = accept ? grant_idx : last_q;
    end

    // Pointer resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= IDX_W'(NUM_CH - 1);
        else        last_q <= last_d;
    end

endmodule

// File: rtl/cac_settings_hub.sv
// cac_settings_hub -- multi-channel settings RAM with default load.
//   clk_cac, rstb_cac    : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-channel request handshake
//   req_write/addr/wdata : per-channel request payload (flattened by channel)
//   rsp_valid            : per-channel one-cycle response pulse
//   rsp_rdata, rsp_err   : shared response data / error, qualified by rsp_valid
//   init_done            : high once the default image has been loaded
// After reset the RAM is filled one word per cycle, then requests are served
// one at a time: accept (IDLE) -> RAM access (ACCESS) -> response (RESP).
module cac_settings_hub
    import cac_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RAM_LENGTH = 64,
    parameter int ROM_LENGTH = 32
) (
    input  logic                         clk_cac,
    input  logic                         rstb_cac,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         init_done
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RAM_AW = (RAM_LENGTH > 1) ? $clog2(RAM_LENGTH) : 1;

    cac_state_e            state_q, state_d;
    logic [RAM_AW-1:0]     init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [IDX_W-1:0]      ch_q, ch_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_CH-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] ram [RAM_LENGTH];
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic [NUM_CH-1:0]     arb_req, grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  accept;
    logic                  addr_ok;
    logic [31:0]           rom_word;

    // Arbiter only sees requests while idle, so grant doubles as req_ready.
    assign arb_req  = (state_q == ST_IDLE) ? req_valid : '0;
    assign accept   = |grant;
    assign addr_ok  = 32'(addr_q) < 32'(RAM_LENGTH);
    assign rom_word = cac_rom_word(32'(init_cnt_q));

    cac_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clk       (clk_cac),
        .rst_n     (rstb_cac),
        .req       (arb_req),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        ch_d        = ch_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_q[RAM_AW-1:0];
        ram_wdata   = wdata_q;

        unique case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = init_cnt_q;
                ram_wdata = (32'(init_cnt_q) < 32'(ROM_LENGTH)) ? DATA_WIDTH'(rom_word) : '0;
                if (32'(init_cnt_q) == 32'(RAM_LENGTH - 1)) begin
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    ch_d    = grant_idx;
                    wr_d    = req_write[grant_idx];
                    addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Out-of-range: no RAM update, data forced to zero, error flagged.
                ram_we      = wr_q && addr_ok;
                rsp_valid_d = NUM_CH'(1) << ch_q;
                rsp_err_d   = !addr_ok;
                if (addr_ok) rsp_rdata_d = wr_q ? wdata_q : ram[ram_addr];
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_cac or negedge rstb_cac) begin
        if (!rstb_cac) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ch_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            ch_q        <= ch_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Single-port array; the read result lands in rsp_rdata_q on the same edge.
    always_ff @(posedge clk_cac) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_cac_settings_hub.sv
// tb_cac_settings_hub -- self-checking bench for cac_settings_hub.
// A behavioural model (settings array + round-robin pointer) predicts every
// grant and response; a fixed vector table and hand sequences cover the
// corner cases, followed by random multi-channel traffic.
module tb_cac_settings_hub;

    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int RL  = 64;
    localparam int RO  = 32;

    logic              clk = 1'b0;
    logic              rstb;
    logic [NCH-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err, init_done;

    always #5 clk = ~clk;

    cac_settings_hub #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RAM_LENGTH(RL), .ROM_LENGTH(RO)
    ) dut (
        .clk_cac(clk), .rstb_cac(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    typedef struct {
        int          ch;
        bit          wr;
        int          addr;
        logic [15:0] wd;
        logic [15:0] exp_d;
        bit          exp_e;
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem [RL];
    int            m_last;

    function automatic logic [DW-1:0] tb_rom(input int i);
        return 16'h5A00 + 16'(i * 'h111);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < RL; i++) mem[i] = (i < RO) ? tb_rom(i) : '0;
        m_last = NCH - 1;
    endtask

    function automatic int model_grant(input logic [NCH-1:0] v);
        for (int k = 1; k <= NCH; k++)
            if (v[(m_last + k) % NCH]) return (m_last + k) % NCH;
        return -1;
    endfunction

    task automatic set_req(input int ch, input bit wr, input int addr, input logic [DW-1:0] wd);
        req_valid[ch]           = 1'b1;
        req_write[ch]           = wr;
        req_addr[ch*AW +: AW]   = AW'(addr);
        req_wdata[ch*DW +: DW]  = wd;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Called at posedge+1 with requests applied. Waits for the accept,
    // checks grant and the 2-cycle response, returns at posedge+1 in IDLE.
    task automatic serve(input bit drop, input string name, output int ch_got,
                         output logic [DW-1:0] got_d, output logic got_e);
        int            waited;
        int            exp_ch;
        int            a;
        bit            w;
        logic [DW-1:0] wd, exp_d;
        logic          exp_e;
        waited = 0;
        ch_got = -1;
        got_d  = '0;
        got_e  = 1'b0;
        #1;
        while (req_ready == '0 && waited < 300) begin
            tick();
            #1;
            waited++;
        end
        if (req_ready == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s accept: no req_ready within 300 cycles", name);
            return;
        end
        exp_ch = model_grant(req_valid);
        chk({name, " grant"}, 32'(req_ready), (exp_ch >= 0) ? (32'd1 << exp_ch) : 32'd0);
        if (exp_ch < 0) exp_ch = 0;
        w  = req_write[exp_ch];
        a  = int'(req_addr[exp_ch*AW +: AW]);
        wd = req_wdata[exp_ch*DW +: DW];
        if (a >= RL) begin
            exp_d = '0;
            exp_e = 1'b1;
        end else if (w) begin
            mem[a] = wd;
            exp_d  = wd;
            exp_e  = 1'b0;
        end else begin
            exp_d = mem[a];
            exp_e = 1'b0;
        end
        m_last = exp_ch;
        @(posedge clk);
        #1;
        if (drop) req_valid[exp_ch] = 1'b0;
        chk({name, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1 << exp_ch);
        chk({name, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_d));
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
        ch_got = exp_ch;
        got_d  = rsp_rdata;
        got_e  = rsp_err;
        tick();
    endtask

    // Counts edges from reset release until init_done; flags any req_ready.
    task automatic wait_init(input string name);
        int cyc;
        bit ready_seen;
        cyc        = 0;
        ready_seen = 1'b0;
        while (!init_done && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!init_done && req_ready != '0) ready_seen = 1'b1;
        end
        chk({name, " init cycles"}, 32'(cyc), 32'(RL));
        chk({name, " ready during INIT"}, 32'(ready_seen), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [13];
        int            order [5];
        int            gc, waited;
        logic [DW-1:0] gd;
        logic          ge;
        logic [NCH-1:0] v;

        tbl[0]  = '{0, 1'b0, 40,  16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{1, 1'b1, 5,   16'hBEEF, 16'hBEEF, 1'b0};
        tbl[2]  = '{1, 1'b0, 5,   16'h0000, 16'hBEEF, 1'b0};
        tbl[3]  = '{2, 1'b1, 64,  16'h1111, 16'h0000, 1'b1};
        tbl[4]  = '{3, 1'b0, 10,  16'h0000, 16'h64AA, 1'b0};
        tbl[5]  = '{0, 1'b1, 31,  16'h1234, 16'h1234, 1'b0};
        tbl[6]  = '{3, 1'b0, 31,  16'h0000, 16'h1234, 1'b0};
        tbl[7]  = '{1, 1'b1, 255, 16'hABCD, 16'h0000, 1'b1};
        tbl[8]  = '{2, 1'b0, 200, 16'h0000, 16'h0000, 1'b1};
        tbl[9]  = '{0, 1'b0, 63,  16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{2, 1'b1, 63,  16'h0F0F, 16'h0F0F, 1'b0};
        tbl[11] = '{1, 1'b0, 63,  16'h0000, 16'h0F0F, 1'b0};
        tbl[12] = '{3, 1'b0, 0,   16'h0000, 16'h5A00, 1'b0};
        order   = '{0, 1, 2, 3, 0};

        // Reset state
        clear_req();
        rstb = 1'b1;
        #1 rstb = 1'b0;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        repeat (3) tick();
        rstb = 1'b1;
        model_reset();
        wait_init("boot");

        // Vector table
        for (int i = 0; i < 13; i++) begin
            set_req(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            serve(1'b1, $sformatf("vec%0d", i), gc, gd, ge);
            clear_req();
            chk($sformatf("vec%0d table rdata", i), 32'(gd), 32'(tbl[i].exp_d));
            chk($sformatf("vec%0d table err", i), 32'(ge), 32'(tbl[i].exp_e));
        end

        // Full readback: out-of-range writes must not have touched anything
        for (int i = 0; i < RL; i++) begin
            set_req(i % NCH, 1'b0, i, '0);
            serve(1'b1, $sformatf("readback%0d", i), gc, gd, ge);
            clear_req();
        end

        // Reset during ACCESS of a write from channel 3
        set_req(3, 1'b1, 7, 16'hDEAD);
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        chk("midrst accept", 32'(req_ready), 32'h8);
        @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("midrst rsp_err", 32'(rsp_err), 32'd0);
        chk("midrst init_done", 32'(init_done), 32'd0);
        clear_req();
        tick();
        chk("midrst no pulse", 32'(rsp_valid), 32'd0);

        // Request held through INIT: accepted in the first IDLE cycle
        set_req(3, 1'b0, 7, '0);
        tick();
        rstb = 1'b1;
        model_reset();
        wait_init("reinit");
        #1;
        chk("first idle ready", 32'(req_ready), 32'h8);
        serve(1'b1, "post-init read", gc, gd, ge);
        clear_req();
        chk("addr7 rom default", 32'(gd), 32'h6177);

        // All channels request continuously
        for (int c = 0; c < NCH; c++) set_req(c, 1'b0, c + 1, '0);
        for (int k = 0; k < 5; k++) begin
            serve(1'b0, $sformatf("hold%0d", k), gc, gd, ge);
            chk($sformatf("hold%0d order", k), 32'(gc), 32'(order[k]));
        end
        clear_req();

        // Random multi-channel traffic
        for (int it = 0; it < 150; it++) begin
            v = NCH'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++)
                if (v[c]) set_req(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 79)), 16'($urandom));
            serve(1'b1, $sformatf("rand%0d", it), gc, gd, ge);
            clear_req();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cac_settings_hub.md
CAC_SETTINGS_HUB -- requirements
Module: cac_settings_hub

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of request channels (legal range 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, settings address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, settings word width.
REQ-004 SHALL have parameter RAM_LENGTH, default 64, number of settings RAM words (legal range 1..2**ADDR_WIDTH).
REQ-005 SHALL have parameter ROM_LENGTH, default 32, number of default words (legal range 0..RAM_LENGTH).
REQ-006 SHALL have port clk_cac, input, 1, the single clock.
REQ-007 SHALL have port rstb_cac, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, NUM_CH, per-channel request valid.
REQ-009 SHALL have port req_ready, output, NUM_CH, per-channel accept.
REQ-010 SHALL have port req_write, input, NUM_CH, 1 means write and 0 means read.
REQ-011 SHALL have port req_addr, input, NUM_CH*ADDR_WIDTH, flattened with channel k in slice [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port req_wdata, input, NUM_CH*DATA_WIDTH, flattened in the same way.
REQ-013 SHALL have port rsp_valid, output, NUM_CH, one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata, output, DATA_WIDTH, shared read data, qualified by rsp_valid.
REQ-015 SHALL have port rsp_err, output, 1, shared error flag, qualified by rsp_valid.
REQ-016 SHALL have port init_done, output, 1, high once the default load completes.

Function
REQ-017 SHALL implement the states INIT, IDLE, ACCESS and RESP.
REQ-018 INIT SHALL write ROM word i to RAM[i] for i < ROM_LENGTH and write zero to the remaining words, one word per cycle, for RAM_LENGTH cycles total, then go to IDLE and set init_done.
REQ-019 In INIT, req_ready SHALL be all zero.
REQ-020 In IDLE, the round-robin arbiter SHALL assert req_ready combinationally for exactly one channel with req_valid high; if no channel is valid, req_ready SHALL be zero.
REQ-021 Arbitration priority SHALL start at channel (last_grant+1) mod NUM_CH; last_grant resets to NUM_CH-1, so channel 0 wins first.
REQ-022 On req_valid&req_ready, the hub SHALL capture the channel, write flag, address and wdata, and go to ACCESS.
REQ-023 In ACCESS, a write to an in-range address SHALL update the RAM, and a read SHALL latch RAM[addr]; then the hub SHALL go to RESP.
REQ-024 An address >= RAM_LENGTH SHALL NOT modify the RAM, SHALL return rsp_rdata=0 and SHALL set rsp_err=1.
REQ-025 In RESP, the hub SHALL pulse rsp_valid[captured channel] for one cycle and then return to IDLE.
REQ-026 Accept-to-response latency SHALL be 2 cycles, giving a maximum throughput of 1 transaction per 3 cycles.
REQ-027 For a write, rsp_rdata SHALL equal the written data, and 0 on error.
REQ-028 Once in IDLE, the hub SHALL never return to INIT except on reset.
REQ-029 A read in the cycle after a write to the same address SHALL return the new value.
REQ-030 A requester SHALL hold its request stable until accepted; the hub SHALL not check this.

Reset
REQ-031 Asserting rstb_cac low SHALL immediately force INIT and clear the INIT counter.
REQ-032 Reset SHALL set req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and init_done=0.
REQ-033 Reset mid-transaction SHALL drop the transaction without any response; RAM contents are then rewritten by INIT.
REQ-034 Release from reset SHALL start INIT on the first rising edge after deassertion.

Structure
REQ-035 The shared package cac_pkg SHALL hold the state encoding, the default-settings ROM image function, and the NUM_CH maximum constant.
REQ-036 The round-robin arbiter SHALL be a sub-module cac_rr_arbiter (request vector in, one-hot grant out, pointer update on an accept strobe).
REQ-037 The RAM SHALL be inferred as a single-port synchronous array.

Verification
REQ-038 Reset release with no requests -> init_done rises after exactly RAM_LENGTH cycles; reading address 40 returns 0 with rsp_err=0.
REQ-039 Channel 1 writes 0xBEEF to address 5, then reads address 5 -> both responses on rsp_valid[1] with rdata 0xBEEF and err 0, each 2 cycles after its accept.
REQ-040 All 4 channels hold reads continuously -> grant order 0,1,2,3,0, with no channel granted twice before the others.
REQ-041 Channel 2 writes address 64 (= RAM_LENGTH) -> rsp_err=1, rdata=0, and a subsequent read of every address is unchanged.
REQ-042 Reset asserted during ACCESS of a write by channel 3 -> no rsp_valid pulse, outputs clear immediately, and after INIT the written address holds its ROM default.
REQ-043 Request asserted during INIT -> req_ready stays 0 until init_done, then is accepted in the first IDLE cycle.
